// File: rtl/spike_generator_array.sv
// Array of periodic spike generators sharing one registered output slot, with round-robin arbitration.
// Latency: a spike appears one cycle after its pending bit sets. Backpressure: the slot holds while out_r=0, and a repeat fire is counted as a drop.
module spike_generator_array #(
    parameter int NumGens = 8,
    parameter int Ngens   = 8,
    parameter int Nperiod = 16,
    parameter int Ntag    = 11,
    parameter int Nct     = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               time_unit_pulse,
    input  logic [Ngens-1:0]   prog_gen_idx,
    input  logic [Nperiod-1:0] prog_period,
    input  logic [Nperiod-1:0] prog_ticks,
    input  logic [Ntag-1:0]    prog_tag,
    input  logic               prog_v,
    output logic               prog_a,
    output logic [Ntag-1:0]    out_tag,
    output logic [Nct-1:0]     out_ct,
    output logic               out_v,
    input  logic               out_r,
    output logic               drop_pulse,
    output logic               bad_idx_pulse
);
    localparam int Pw = (NumGens > 1) ? $clog2(NumGens) : 1;

    logic [Nperiod-1:0] period_q [NumGens];
    logic [Nperiod-1:0] count_q  [NumGens];
    logic [Ntag-1:0]    tag_q    [NumGens];
    logic [NumGens-1:0] pending_q;
    logic [Pw-1:0]      ptr_q;

    logic               accept;
    logic               bad_idx;
    logic               load_en;
    logic               sel_found;
    logic [Pw-1:0]      sel;
    logic [Pw-1:0]      cand;
    logic [NumGens-1:0] prog_hit;
    logic [NumGens-1:0] fire;
    logic [NumGens-1:0] clr;

    // prog_a high blocks a second accept, so each word is taken exactly once
    assign accept  = prog_v && !prog_a;
    assign bad_idx = prog_gen_idx >= Ngens'(NumGens);
    assign load_en = !out_v || out_r;

    always_comb begin
        prog_hit = '0;
        fire     = '0;
        for (int i = 0; i < NumGens; i++) begin
            prog_hit[i] = accept && (prog_gen_idx == Ngens'(i));
            fire[i]     = time_unit_pulse && !prog_hit[i] && (period_q[i] != '0)
                          && (count_q[i] <= Nperiod'(1));
        end
    end

    // First pending generator at or after the pointer, wrapping around
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        cand      = '0;
        clr       = '0;
        for (int k = 0; k < NumGens; k++) begin
            cand = Pw'((int'(ptr_q) + k) % NumGens);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
        if (load_en && sel_found) clr[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NumGens; i++) begin
                period_q[i] <= '0;
                count_q[i]  <= '0;
                tag_q[i]    <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int i = 0; i < NumGens; i++) begin
                if (prog_hit[i]) begin
                    period_q[i] <= prog_period;
                    count_q[i]  <= prog_ticks;
                    tag_q[i]    <= prog_tag;
                end else if (fire[i]) begin
                    count_q[i] <= period_q[i];
                end else if (time_unit_pulse && (period_q[i] != '0)) begin
                    count_q[i] <= count_q[i] - Nperiod'(1);
                end
            end
            // A fire in the same cycle as its slot load re-arms the bit without a drop
            pending_q <= (pending_q & ~clr & ~prog_hit) | fire;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q         <= '0;
            out_v         <= 1'b0;
            out_tag       <= '0;
            out_ct        <= '0;
            prog_a        <= 1'b0;
            drop_pulse    <= 1'b0;
            bad_idx_pulse <= 1'b0;
        end else begin
            prog_a        <= accept;
            bad_idx_pulse <= accept && bad_idx;
            drop_pulse    <= |(fire & pending_q & ~clr);
            if (load_en) begin
                out_v <= sel_found;
                if (sel_found) begin
                    out_tag <= tag_q[sel];
                    out_ct  <= Nct'(1);
                    ptr_q   <= Pw'((int'(sel) + 1) % NumGens);
                end
            end
        end
    end
endmodule

// File: tb/tb_spike_generator_array.sv
// Directed bench for spike_generator_array: periodic firing, arbitration, stall/drop, bad index, disable, reset.
module tb_spike_generator_array;
    localparam int NumGens = 8;
    localparam int Ngens   = 8;
    localparam int Nperiod = 16;
    localparam int Ntag    = 11;
    localparam int Nct     = 10;

    logic               clk;
    logic               reset_n;
    logic               time_unit_pulse;
    logic [Ngens-1:0]   prog_gen_idx;
    logic [Nperiod-1:0] prog_period;
    logic [Nperiod-1:0] prog_ticks;
    logic [Ntag-1:0]    prog_tag;
    logic               prog_v;
    logic               prog_a;
    logic [Ntag-1:0]    out_tag;
    logic [Nct-1:0]     out_ct;
    logic               out_v;
    logic               out_r;
    logic               drop_pulse;
    logic               bad_idx_pulse;

    int n_assert = 0;
    int n_fail   = 0;
    int seen;

    spike_generator_array #(
        .NumGens(NumGens), .Ngens(Ngens), .Nperiod(Nperiod), .Ntag(Ntag), .Nct(Nct)
    ) dut (
        .clk(clk), .reset_n(reset_n), .time_unit_pulse(time_unit_pulse),
        .prog_gen_idx(prog_gen_idx), .prog_period(prog_period), .prog_ticks(prog_ticks),
        .prog_tag(prog_tag), .prog_v(prog_v), .prog_a(prog_a),
        .out_tag(out_tag), .out_ct(out_ct), .out_v(out_v), .out_r(out_r),
        .drop_pulse(drop_pulse), .bad_idx_pulse(bad_idx_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic prog_gen(input int idx, input int per, input int tk, input int tg,
                            input logic exp_bad);
        prog_gen_idx = Ngens'(idx);
        prog_period  = Nperiod'(per);
        prog_ticks   = Nperiod'(tk);
        prog_tag     = Ntag'(tg);
        prog_v       = 1'b1;
        @(negedge clk);
        chk("prog_a_high", prog_a, 1);
        chk("bad_idx_with_ack", bad_idx_pulse, exp_bad);
        prog_v = 1'b0;
        @(negedge clk);
        chk("prog_a_low", prog_a, 0);
        chk("bad_idx_low", bad_idx_pulse, 0);
    endtask

    task automatic pulse();
        time_unit_pulse = 1'b1;
        @(negedge clk);
        time_unit_pulse = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; time_unit_pulse = 1'b0; prog_gen_idx = '0; prog_period = '0;
        prog_ticks = '0; prog_tag = '0; prog_v = 1'b0; out_r = 1'b1;
        @(negedge clk);
        chk("rst_out_v", out_v, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_ct", out_ct, 0);
        chk("rst_prog_a", prog_a, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_bad_idx", bad_idx_pulse, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Period 3, phase 1: fires on pulses 1, 4, 7
        prog_gen(2, 3, 1, 'h055, 1'b0);
        for (int p = 1; p <= 7; p++) begin
            pulse();
            @(negedge clk);
            chk("p3_out_v", out_v, (p == 1 || p == 4 || p == 7) ? 1 : 0);
            if (out_v) begin
                chk("p3_out_tag", out_tag, 'h055);
                chk("p3_out_ct", out_ct, 1);
            end
            chk("p3_no_drop", drop_pulse, 0);
        end

        // Three generators all firing each time unit, drained in index order
        do_reset();
        prog_gen(0, 1, 1, 'h100, 1'b0);
        prog_gen(1, 1, 1, 'h101, 1'b0);
        prog_gen(2, 1, 1, 'h102, 1'b0);
        for (int r = 0; r < 2; r++) begin
            pulse();
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk("rr_out_v", out_v, 1);
                chk("rr_out_tag", out_tag, 'h100 + j);
                chk("rr_no_drop", drop_pulse, 0);
            end
            @(negedge clk);
            chk("rr_idle", out_v, 0);
        end

        // Stalled output: one spike held, one pending, third fire drops
        do_reset();
        prog_gen(0, 1, 1, 'h0AA, 1'b0);
        out_r = 1'b0;
        pulse();
        chk("stall_first_empty", out_v, 0);
        pulse();
        chk("stall_loaded", out_v, 1);
        chk("stall_tag1", out_tag, 'h0AA);
        chk("stall_no_drop_reload", drop_pulse, 0);
        pulse();
        chk("stall_drop", drop_pulse, 1);
        chk("stall_hold_v", out_v, 1);
        chk("stall_hold_tag", out_tag, 'h0AA);
        chk("stall_hold_ct", out_ct, 1);
        @(negedge clk);
        chk("stall_drop_one_cycle", drop_pulse, 0);
        chk("stall_hold_v2", out_v, 1);
        out_r = 1'b1;
        @(negedge clk);
        chk("stall_pending_spike", out_v, 1);
        @(negedge clk);
        chk("stall_drained", out_v, 0);

        // Out-of-range index: acknowledged and flagged, otherwise ignored
        do_reset();
        prog_gen(9, 1, 1, 'h7FF, 1'b1);
        seen = 0;
        for (int p = 0; p < 5; p++) begin
            pulse();
            if (out_v) seen++;
            @(negedge clk);
            if (out_v) seen++;
        end
        chk("bad_idx_no_spikes", seen, 0);

        // Disabled generator, then re-enabled
        do_reset();
        prog_gen(3, 0, 1, 'h033, 1'b0);
        seen = 0;
        for (int p = 0; p < 100; p++) begin
            pulse();
            if (out_v) seen++;
            @(negedge clk);
            if (out_v) seen++;
        end
        chk("disabled_no_spikes", seen, 0);
        prog_gen(3, 2, 2, 'h033, 1'b0);
        pulse();
        @(negedge clk);
        chk("reen_pulse1_none", out_v, 0);
        pulse();
        @(negedge clk);
        chk("reen_pulse2_spike", out_v, 1);
        chk("reen_tag", out_tag, 'h033);

        // Reset during an output stall and a programming handshake
        do_reset();
        prog_gen(0, 1, 1, 'h0AA, 1'b0);
        out_r = 1'b0;
        pulse();
        @(negedge clk);
        chk("mid_out_v_before", out_v, 1);
        prog_gen_idx = Ngens'(1); prog_period = Nperiod'(1); prog_ticks = Nperiod'(1);
        prog_tag = Ntag'('h011); prog_v = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_prog_a_before", prog_a, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_v", out_v, 0);
        chk("mid_rst_prog_a", prog_a, 0);
        chk("mid_rst_out_tag", out_tag, 0);
        @(negedge clk);
        reset_n = 1'b1; prog_v = 1'b0; out_r = 1'b1;
        @(negedge clk);
        seen = 0;
        for (int p = 0; p < 5; p++) begin
            pulse();
            if (out_v) seen++;
            @(negedge clk);
            if (out_v) seen++;
        end
        chk("post_rst_no_spikes", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/spike_generator_array.md
SPIKE_GENERATOR_ARRAY -- requirements
Module: spike_generator_array

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NumGens, 8, number of generators implemented.
REQ-002 Ngens, 8, gen_idx width.
REQ-003 Nperiod, 16, period/ticks width.
REQ-004 Ntag, 11, tag width.
REQ-005 Nct, 10, count width.
REQ-006 Ports SHALL be (name, direction, width, meaning): clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 reset_n, input, 1, asynchronous active-low reset.
REQ-008 time_unit_pulse, input, 1, one-cycle strobe marking a time-unit boundary.
REQ-009 prog_gen_idx, input, Ngens, generator to program.
REQ-010 prog_period, input, Nperiod, spike period in time units; 0 = disabled.
REQ-011 prog_ticks, input, Nperiod, initial countdown (phase).
REQ-012 prog_tag, input, Ntag, tag emitted by this generator.
REQ-013 prog_v, input, 1, programming word valid.
REQ-014 prog_a, output, 1, programming word acknowledged.
REQ-015 out_tag, output, Ntag, spike tag.
REQ-016 out_ct, output, Nct, spike count.
REQ-017 out_v, output, 1, spike valid.
REQ-018 out_r, input, 1, downstream ready.
REQ-019 drop_pulse, output, 1, one-cycle flag: a spike was lost.
REQ-020 bad_idx_pulse, output, 1, one-cycle flag: prog_gen_idx >= NumGens.

Function
REQ-021 Per generator state SHALL be: period, count, tag registers plus a pending bit.
REQ-022 Programming accept SHALL occur on a cycle with prog_v=1 and prog_a=0; prog_a SHALL be registered, high exactly the cycle after accept, then low for at least one cycle.
REQ-023 On accept with valid index: period<=prog_period, count<=prog_ticks, tag<=prog_tag, pending<=0.
REQ-024 On accept with index >= NumGens: no state change, prog_a still asserted, bad_idx_pulse high with prog_a.
REQ-025 On time_unit_pulse, each enabled generator (period!=0) with count>1 SHALL decrement count.
REQ-026 On time_unit_pulse with count<=1 and period!=0: fire; count<=period; pending<=1.
REQ-027 Fire while pending already 1: pending stays 1, drop_pulse asserted next cycle (OR over generators).
REQ-028 Disabled generators (period=0) SHALL never fire and hold count.
REQ-029 Programming a generator in the same cycle as time_unit_pulse: programming wins for that generator; no fire, no decrement.
REQ-030 Output stage: single registered slot; out_v=1 holds out_tag/out_ct stable until out_v&&out_r.
REQ-031 out_ct SHALL always equal 1.
REQ-032 Slot load: when slot empty or draining (out_v&&out_r), pick lowest pending index at or after round-robin pointer (wrapping); clear its pending; pointer<=selected+1 mod NumGens.
REQ-033 Throughput: one spike per cycle when out_r held 1; first spike out_v one cycle after pending set.
REQ-034 A pending bit cleared by slot load in the same cycle it is re-set by fire SHALL end at 1, no drop.
REQ-035 Generator outputs only at slot load; reprogramming a generator SHALL not alter a spike already in the slot.

Reset
REQ-036 Asserting reset_n=0 SHALL immediately clear: all period/count/tag/pending, pointer=0, out_v=0, out_tag=0, out_ct=0, prog_a=0, drop_pulse=0, bad_idx_pulse=0.
REQ-037 Reset mid-handshake SHALL discard in-flight programming and output spike; after release, no output until reprogrammed.

Verification
REQ-038 Program gen 2 period=3 ticks=1 tag=0x055, out_r=1, 7 time_unit_pulses -> spikes tag 0x055 ct 1 after pulses 1, 4, 7.
REQ-039 Gens 0,1,2 all period=1, out_r=1 -> each time unit emits tags in order 0,1,2, pointer rotates; no drop.
REQ-040 Gen 0 period=1, out_r=0 for 3 time units -> one spike held in slot, one pending, drop_pulse on third pulse; outputs stable while stalled.
REQ-041 prog_gen_idx=9 (NumGens=8) -> prog_a and bad_idx_pulse one cycle, no spikes ever.
REQ-042 Program period=0 -> no spikes over 100 time units; reprogram period=2 ticks=2 -> spike after second pulse.
REQ-043 Drop reset_n while out_v=1 and prog_v=1 -> out_v=0 and prog_a=0 immediately, no spikes after release.
